// File: rtl/dsp_shift_add_mul_if.sv
// Request/response bundle for dsp_shift_add_mul: operands and start in,
// busy/done/result out.
interface dsp_shift_add_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op_a, op_b, input busy, done, result);
  modport slave  (input start, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/dsp_shift_add_mul.sv
// Multi-cycle 32x32 shift-add multiplier (low 32 bits) using an external adder.
// Optional macro DSP_MUL_EARLY_TERM_EN ends iterations once the multiplier is exhausted.
module dsp_shift_add_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  dsp_shift_add_mul_if.slave   bus,
  output logic [WIDTH-1:0]     add_in1,
  output logic [WIDTH-1:0]     add_in2,
  input  logic [WIDTH-1:0]     add_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // Final iteration: all WIDTH bits consumed, or (optionally) no set bits remain.
`ifdef DSP_MUL_EARLY_TERM_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // Adder inputs are forced to zero outside ITER so the adder stays quiet.
  always_comb begin
    add_in1 = '0;
    add_in2 = '0;
    if (state == ITER) begin
      add_in1 = acc;
      add_in2 = mplier[0] ? mcand : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            mcand    <= bus.op_a;
            mplier   <= bus.op_b;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= ITER;
          end
        end
        ITER: begin
          acc    <= add_out;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            // The sum landing in acc this edge is the final product.
            bus.result <= add_out;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dsp_shift_add_mul.md
Name: dsp_shift_add_mul

Overview:
- Multi-cycle 32x32 unsigned multiplier for the RV32 datapath. Produces the low 32 bits of the product, matching the RV32M MUL result.
- Computes no sums internally. Each iteration it drives operands into the external 32-bit combinational DSP adder and registers the sum that adder returns.
- Sits directly upstream of the adder: it feeds the adder's two inputs and consumes its output.

Parameters:
- WIDTH, 32, operand/result/adder width. Only 32 is supported.
- CNT_W, 6, iteration-counter width. Must hold the value WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op_a  in  32  multiplicand; captured when start is accepted
- op_b  in  32  multiplier; captured when start is accepted
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; result is valid in this cycle
- result  out  32  low 32 bits of op_a*op_b
- add_in1  out  32  to external adder input1
- add_in2  out  32  to external adder input2
- add_out  in  32  from external adder out; purely combinational from add_in1/add_in2

Behaviour:
- Reset: the reset value of every output is 0, including busy, done, result, add_in1 and add_in2. Internal registers (acc, mcand, mplier, cnt) clear to 0. State goes to IDLE. Reset overrides any operation in flight; there is no partial result and no done pulse.
- States: IDLE, ITER, DONE.
- IDLE:
  - start=1: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, go to ITER.
  - start=0: stay in IDLE.
- ITER (combinational outputs):
  - add_in1 = acc.
  - add_in2 = mplier[0] ? mcand : 0.
- ITER (clock edge):
  - acc <= add_out, truncated to 32 bits; carry out is discarded.
  - mcand <= mcand<<1, with bits shifted beyond bit 31 discarded.
  - mplier <= mplier>>1, zero-filled.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
- DONE:
  - result <= acc, registered on entry so result is valid while done=1.
  - done=1 for exactly one cycle, then return to IDLE.
- Outside ITER, add_in1 and add_in2 are held at 0 so the adder toggles only during iterations.
- Latency: start accepted at edge N; ITER occupies cycles N+1..N+32; done=1 in cycle N+33. Throughput is one operation per 34 cycles.
- start while busy=1 is ignored; the operation in progress is not disturbed. start in the DONE cycle is also ignored. start in the cycle after done is accepted.
- result holds its value until the next done; it does not change on start.
- Arithmetic is modulo 2^32 on unsigned operands, so the low 32 bits of a signed product are also correct.
- Boundary values: op_a=0 or op_b=0 gives result 0. 0xFFFFFFFF*0xFFFFFFFF gives 0x00000001.

Optional Feature:
- Macro: DSP_MUL_EARLY_TERM_EN.
- Defined: in ITER, move to DONE when the next mplier value (mplier>>1) is 0, or when cnt==WIDTH-1, whichever comes first. Latency is 2 + the index of the highest set bit of op_b, with op_b=0 counting as 1 iteration. For example, op_b=0 or op_b=1 gives done at N+2, and op_b=0x80000000 gives done at N+33.
- Not defined: latency is fixed at 33 cycles from start to done.
- Results are identical either way.

Test Plan:
- Reset, then start with op_a=3, op_b=5 -> busy=1 from N+1; done=1 only in cycle N+33; result=0x0000000F.
- op_a=0x0000FFFF, op_b=0x0000FFFF -> result=0xFFFE0001. op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001. op_a=0x00AF0000, op_b=0x0AFD0000 -> result=0x00000000.
- Start op_a=7, op_b=9; pulse start with op_a=2, op_b=2 at N+10 -> still exactly one done at N+33 with result=0x0000003F. Back-to-back start in the cycle after done -> accepted.
- Reset asserted at N+15 during ITER -> next cycle busy=0, done=0, result=0, add_in1=add_in2=0. No done appears afterwards. A new start then completes normally.
- Check add_in1/add_in2 every ITER cycle against a reference model. Outside ITER both must be 0.
- With DSP_MUL_EARLY_TERM_EN: op_b=1 -> done at N+2; op_b=0x00000100 -> done at N+10; op_b=0x80000000 -> done at N+33. Products must match the non-early-term build.
